// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop sit behind a start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_D,
  output logic             o_Bout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] sh_d_q;
  logic             borrow_q;
  logic [CW-1:0]    count_q;

  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] sh_d_next;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    diff_bit    = sh_a_q[0] ^ sh_b_q[0] ^ borrow_q;
    borrow_next = (~sh_a_q[0] & sh_b_q[0]) | (~(sh_a_q[0] ^ sh_b_q[0]) & borrow_q);
    sh_d_next   = sh_d_q >> 1;
    sh_d_next[WIDTH-1] = diff_bit;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_d_q   <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_D      <= '0;
      o_Bout   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          o_done <= 1'b0;
          if (i_start) begin
            sh_a_q   <= i_A;
            sh_b_q   <= i_B;
            borrow_q <= i_Bin;
            sh_d_q   <= '0;
            count_q  <= '0;
            o_busy   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          sh_a_q   <= sh_a_q >> 1;
          sh_b_q   <= sh_b_q >> 1;
          sh_d_q   <= sh_d_next;
          borrow_q <= borrow_next;
          count_q  <= count_q + CW'(1);
          // The last bit's result goes straight to the outputs on this edge.
          if (count_q == LastBit) begin
            o_D     <= sh_d_next;
            o_Bout  <= borrow_next;
            o_done  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): handshake timing, borrow cases,
// exhaustive sweep, start-while-busy, back-to-back and mid-operation reset.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  int n_checks;
  int n_err;
  logic [WIDTH-1:0] prev_d;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_A     (a),
    .i_B     (b),
    .i_Bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_D     (d),
    .o_Bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one active edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation with timing checks; exp is the 5-bit {Bout, D} reference.
  task automatic run_op(input logic [3:0] oa, input logic [3:0] ob, input logic obin,
                        input bit full);
    logic [4:0] exp;
    exp = {1'b0, oa} - {1'b0, ob} - {4'b0000, obin};
    start = 1'b1; a = oa; b = ob; bin = obin;
    step();  // E0
    start = 1'b0; a = ~oa; b = ~ob; bin = ~obin;
    if (full) begin
      check("busy_after_e0", 32'(busy), 32'd1);
      check("done_after_e0", 32'(done), 32'd0);
    end
    for (int k = 1; k < int'(WIDTH); k++) begin
      step();
      if (full && k == 1) check("d_hold_in_run", 32'(d), 32'(prev_d));
      if (full) check("no_early_done", 32'(done), 32'd0);
    end
    step();  // EWIDTH
    check("done_pulse", 32'(done), 32'd1);
    check("diff", 32'(d), 32'(exp[3:0]));
    check("bout", 32'(bout), 32'(exp[4]));
    step();  // EWIDTH+1
    if (full) begin
      check("done_clear", 32'(done), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
      check("d_hold_idle", 32'(d), 32'(exp[3:0]));
    end
    prev_d = exp[3:0];
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    prev_d = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed arithmetic cases.
    run_op(4'd5, 4'd3, 1'b0, 1'b1);    // 2, no borrow
    run_op(4'd3, 4'd5, 1'b0, 1'b1);    // E, borrow
    run_op(4'd0, 4'd0, 1'b1, 1'b1);    // F, borrow
    run_op(4'd15, 4'd15, 1'b1, 1'b1);  // F, borrow
    run_op(4'd8, 4'd0, 1'b1, 1'b1);    // 7, no borrow

    // Exhaustive sweep against the 5-bit reference.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run_op(4'(ia), 4'(ib), 1'(ic), 1'b0);

    // Start while busy: second request at E2 must be ignored.
    start = 1'b1; a = 4'd9; b = 4'd4; bin = 1'b0;
    step();  // E0
    start = 1'b0;
    step();  // E1
    start = 1'b1; a = 4'd1; b = 4'd2;
    step();  // E2
    start = 1'b0;
    check("busy_ignore_start", 32'(busy), 32'd1);
    step();  // E3
    step();  // E4
    check("busy_op_done", 32'(done), 32'd1);
    check("busy_op_d", 32'(d), 32'd5);
    check("busy_op_bout", 32'(bout), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("no_second_done", 32'(done), 32'd0);
    end
    check("idle_after_ignore", 32'(busy), 32'd0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    start = 1'b1; a = 4'd6; b = 4'd1; bin = 1'b0;
    step();  // E0
    for (int k = 0; k < 4; k++) step();  // E4
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_d1", 32'(d), 32'd5);
    a = 4'd10; b = 4'd3;
    step();  // E5
    check("b2b_gap", 32'(done), 32'd0);
    step();  // E6 accepts second op
    check("b2b_busy2", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();  // E10
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_d2", 32'(d), 32'd7);
    step();
    step();

    // Mid-operation reset aborts with no done.
    start = 1'b1; a = 4'd7; b = 4'd1; bin = 1'b0;
    step();  // E0
    start = 1'b0;
    step();  // E1
    rst_n = 1'b0;
    step();  // E2
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_d", 32'(d), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("midrst_no_done", 32'(done), 32'd0);
    end
    prev_d = '0;
    run_op(4'd7, 4'd1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
